// File: rtl/mem_access_stage_if.sv
// Interface bundling the memory-access stage's upstream handshake,
// data-memory req/ack bus and register-file writeback signals.
//
// Modports:
//   master - the stage itself: consumes execute-stage inputs and bus
//            responses; drives stall, the bus request side, writeback and
//            bus_err.
//   slave  - the environment (execute stage, memory, register file).
//
// Signal summary:
//   in_valid/in_mem_read/in_mem_write/in_addr/in_store_data/
//   in_reg_write/in_reg_addr/in_alu_value   execute -> stage
//   stall                                   stage -> execute
//   bus_req/bus_we/bus_addr/bus_wdata       stage -> memory
//   bus_ack/bus_rdata                       memory -> stage
//   writable/write_addr/write_value         stage -> register file
//   bus_err                                 stage -> fault logic (pulse)
interface mem_access_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 16
);
  logic              in_valid;
  logic              in_mem_read;
  logic              in_mem_write;
  logic [MEM_AW-1:0] in_addr;
  logic [DATA_W-1:0] in_store_data;
  logic              in_reg_write;
  logic [REG_AW-1:0] in_reg_addr;
  logic [DATA_W-1:0] in_alu_value;
  logic              stall;

  logic              bus_req;
  logic              bus_we;
  logic [MEM_AW-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  logic              writable;
  logic [REG_AW-1:0] write_addr;
  logic [DATA_W-1:0] write_value;
  logic              bus_err;

  modport master (
    input  in_valid, in_mem_read, in_mem_write, in_addr, in_store_data,
           in_reg_write, in_reg_addr, in_alu_value,
           bus_ack, bus_rdata,
    output stall, bus_req, bus_we, bus_addr, bus_wdata,
           writable, write_addr, write_value, bus_err
  );

  modport slave (
    output in_valid, in_mem_read, in_mem_write, in_addr, in_store_data,
           in_reg_write, in_reg_addr, in_alu_value,
           bus_ack, bus_rdata,
    input  stall, bus_req, bus_we, bus_addr, bus_wdata,
           writable, write_addr, write_value, bus_err
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage of the 16-bit pipeline, between execute and the
// register-file write port. Accepts one instruction per handshake, runs at
// most one data-memory transaction on a req/ack bus, stalls upstream while
// that transaction is in flight, and issues a one-cycle register write per
// retiring instruction. A bus transaction with no ack for TIMEOUT cycles is
// aborted with a one-cycle bus_err pulse and no writeback.
//
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - asynchronous active-low reset
//   mif  - mem_access_stage_if.master (upstream, bus, writeback, bus_err)
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | ready; accepts in_valid, ALU ops retire the next cycle
// S_BUS  | memory transaction outstanding; stall and bus_req asserted
module mem_access_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 4,
  parameter int MEM_AW  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_stage_if.master mif
);

  typedef enum logic {S_IDLE, S_BUS} state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d, cnt_inc;
  logic              timeout_hit;

  logic              bus_we_q, bus_we_d;
  logic [MEM_AW-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              lat_reg_write_q, lat_reg_write_d;
  logic [REG_AW-1:0] lat_reg_addr_q, lat_reg_addr_d;

  logic              writable_q, writable_d;
  logic [REG_AW-1:0] write_addr_q, write_addr_d;
  logic [DATA_W-1:0] write_value_q, write_value_d;
  logic              bus_err_q, bus_err_d;

  // Saturating increment: the count can never wrap past TIMEOUT.
  always_comb begin
    cnt_inc     = (cnt_q >= TIMEOUT_C) ? cnt_q : cnt_q + 16'd1;
    timeout_hit = (cnt_inc >= TIMEOUT_C);
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bus_we_d        = bus_we_q;
    bus_addr_d      = bus_addr_q;
    bus_wdata_d     = bus_wdata_q;
    lat_reg_write_d = lat_reg_write_q;
    lat_reg_addr_d  = lat_reg_addr_q;
    writable_d      = 1'b0;
    write_addr_d    = write_addr_q;
    write_value_d   = write_value_q;
    bus_err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (mif.in_valid) begin
          if (mif.in_mem_read || mif.in_mem_write) begin
            state_d         = S_BUS;
            // read+write together is treated as a store
            bus_we_d        = mif.in_mem_write;
            bus_addr_d      = mif.in_addr;
            bus_wdata_d     = mif.in_store_data;
            lat_reg_write_d = mif.in_reg_write;
            lat_reg_addr_d  = mif.in_reg_addr;
          end else if (mif.in_reg_write) begin
            writable_d    = 1'b1;
            write_addr_d  = mif.in_reg_addr;
            write_value_d = mif.in_alu_value;
          end
        end
      end

      S_BUS: begin
        cnt_d = cnt_inc;
        // ack on the timeout edge still completes normally
        if (mif.bus_ack) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (!bus_we_q && lat_reg_write_q) begin
            writable_d    = 1'b1;
            write_addr_d  = lat_reg_addr_q;
            write_value_d = mif.bus_rdata;
          end
        end else if (timeout_hit) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          bus_err_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      bus_we_q        <= 1'b0;
      bus_addr_q      <= '0;
      bus_wdata_q     <= '0;
      lat_reg_write_q <= 1'b0;
      lat_reg_addr_q  <= '0;
      writable_q      <= 1'b0;
      write_addr_q    <= '0;
      write_value_q   <= '0;
      bus_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bus_we_q        <= bus_we_d;
      bus_addr_q      <= bus_addr_d;
      bus_wdata_q     <= bus_wdata_d;
      lat_reg_write_q <= lat_reg_write_d;
      lat_reg_addr_q  <= lat_reg_addr_d;
      writable_q      <= writable_d;
      write_addr_q    <= write_addr_d;
      write_value_q   <= write_value_d;
      bus_err_q       <= bus_err_d;
    end
  end

  // stall/bus_req decode registered state only: no input-to-output path.
  assign mif.stall       = (state_q == S_BUS);
  assign mif.bus_req     = (state_q == S_BUS);
  assign mif.bus_we      = bus_we_q;
  assign mif.bus_addr    = bus_addr_q;
  assign mif.bus_wdata   = bus_wdata_q;
  assign mif.writable    = writable_q;
  assign mif.write_addr  = write_addr_q;
  assign mif.write_value = write_value_q;
  assign mif.bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage (TIMEOUT = 4). Expected register
// writes are queued when the instruction is driven and checked by a monitor
// whenever writable is seen high; bus timing is checked inline.
module tb_mem_access_stage;
  localparam int DATA_W  = 16;
  localparam int REG_AW  = 4;
  localparam int MEM_AW  = 16;
  localparam int TIMEOUT = 4;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] value;
  } wb_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_err_pulses = 0;
  wb_t  wb_q[$];

  mem_access_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_AW(MEM_AW)) bus_if();

  mem_access_stage #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_AW(MEM_AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mif(bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr,
                       input logic [MEM_AW-1:0] addr, input logic [DATA_W-1:0] sdata,
                       input logic rw, input logic [REG_AW-1:0] ra,
                       input logic [DATA_W-1:0] alu);
    bus_if.in_valid      = v;
    bus_if.in_mem_read   = rd;
    bus_if.in_mem_write  = wr;
    bus_if.in_addr       = addr;
    bus_if.in_store_data = sdata;
    bus_if.in_reg_write  = rw;
    bus_if.in_reg_addr   = ra;
    bus_if.in_alu_value  = alu;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"},    bus_if.stall, 0);
    check({tag, "_bus_req"},  bus_if.bus_req, 0);
    check({tag, "_bus_we"},   bus_if.bus_we, 0);
    check({tag, "_bus_addr"}, bus_if.bus_addr, 0);
    check({tag, "_bus_wdata"}, bus_if.bus_wdata, 0);
    check({tag, "_writable"}, bus_if.writable, 0);
    check({tag, "_wr_addr"},  bus_if.write_addr, 0);
    check({tag, "_wr_value"}, bus_if.write_value, 0);
    check({tag, "_bus_err"},  bus_if.bus_err, 0);
  endtask

  // Scoreboard: every writeback must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && bus_if.writable) begin
      if (wb_q.size() == 0) begin
        check("wb_unexpected", bus_if.writable, 0);
      end else begin
        wb_t e;
        e = wb_q.pop_front();
        check("wb_addr",  bus_if.write_addr, e.addr);
        check("wb_value", bus_if.write_value, e.value);
      end
    end
    if (rst && bus_if.bus_err) n_err_pulses++;
  end

  initial begin
    drive_idle();
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;

    // reset
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b1;

    // ALU op
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 4'd3, 16'h1234);
    wb_q.push_back('{4'd3, 16'h1234});
    tick();
    drive_idle();
    check("alu_writable", bus_if.writable, 1);
    check("alu_stall", bus_if.stall, 0);
    tick();
    check("alu_writable_drop", bus_if.writable, 0);
    check("alu_addr_hold", bus_if.write_addr, 3);

    // load with ack 3 cycles after bus_req, ALU op waiting upstream
    drive(1'b1, 1'b1, 1'b0, 16'h8000, '0, 1'b1, 4'd5, '0);
    wb_q.push_back('{4'd5, 16'hBEEF});
    tick();
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 4'd7, 16'h5555);
    wb_q.push_back('{4'd7, 16'h5555});
    check("ld_stall_c1", bus_if.stall, 1);
    check("ld_req_c1", bus_if.bus_req, 1);
    check("ld_we", bus_if.bus_we, 0);
    check("ld_addr", bus_if.bus_addr, 16'h8000);
    check("ld_writable_c1", bus_if.writable, 0);
    tick();
    check("ld_stall_c2", bus_if.stall, 1);
    tick();
    check("ld_stall_c3", bus_if.stall, 1);
    check("ld_addr_c3", bus_if.bus_addr, 16'h8000);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 16'hBEEF;
    tick();
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;
    check("ld_stall_done", bus_if.stall, 0);
    check("ld_req_done", bus_if.bus_req, 0);
    check("ld_writable", bus_if.writable, 1);
    tick();
    drive_idle();
    check("b2b_writable", bus_if.writable, 1);
    tick();
    check("b2b_writable_drop", bus_if.writable, 0);

    // store, ack in the first BUS cycle
    drive(1'b1, 1'b0, 1'b1, 16'h0010, 16'h00FF, 1'b1, 4'd9, '0);
    tick();
    drive_idle();
    check("st_req", bus_if.bus_req, 1);
    check("st_we", bus_if.bus_we, 1);
    check("st_addr", bus_if.bus_addr, 16'h0010);
    check("st_wdata", bus_if.bus_wdata, 16'h00FF);
    bus_if.bus_ack = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    check("st_req_drop", bus_if.bus_req, 0);
    check("st_writable", bus_if.writable, 0);

    // read+write together behaves as a store
    drive(1'b1, 1'b1, 1'b1, 16'h0020, 16'h0A0A, 1'b1, 4'd10, '0);
    tick();
    drive_idle();
    check("rw_we", bus_if.bus_we, 1);
    check("rw_wdata", bus_if.bus_wdata, 16'h0A0A);
    bus_if.bus_ack = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    check("rw_writable", bus_if.writable, 0);

    // timeout: load with no ack
    drive(1'b1, 1'b1, 1'b0, 16'h1234, '0, 1'b1, 4'd6, '0);
    tick();
    drive_idle();
    for (int i = 0; i < TIMEOUT; i++) begin
      check($sformatf("to_req_c%0d", i + 1), bus_if.bus_req, 1);
      check($sformatf("to_err_c%0d", i + 1), bus_if.bus_err, 0);
      tick();
    end
    check("to_req_drop", bus_if.bus_req, 0);
    check("to_err_pulse", bus_if.bus_err, 1);
    check("to_writable", bus_if.writable, 0);
    tick();
    check("to_err_drop", bus_if.bus_err, 0);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 16'hDEAD;
    tick();
    bus_if.bus_ack = 1'b0;
    check("idle_ack_stall", bus_if.stall, 0);
    check("idle_ack_req", bus_if.bus_req, 0);
    check("idle_ack_writable", bus_if.writable, 0);

    // asynchronous reset during BUS
    drive(1'b1, 1'b1, 1'b0, 16'h2000, '0, 1'b1, 4'd4, '0);
    tick();
    drive_idle();
    check("rst_pre_req", bus_if.bus_req, 1);
    #2 rst = 1'b0;
    #1 check_all_zero("async_rst");
    tick();
    rst = 1'b1;
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 16'h7777;
    tick();
    bus_if.bus_ack = 1'b0;
    check("post_rst_writable", bus_if.writable, 0);
    check("post_rst_err", bus_if.bus_err, 0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 4'd2, 16'hA5A5);
    wb_q.push_back('{4'd2, 16'hA5A5});
    tick();
    drive_idle();
    check("post_rst_alu", bus_if.writable, 1);

    // ack on the same edge as the timeout wins
    drive(1'b1, 1'b1, 1'b0, 16'h3000, '0, 1'b1, 4'd8, '0);
    wb_q.push_back('{4'd8, 16'h0042});
    tick();
    drive_idle();
    tick(); tick(); tick();
    check("race_req_c4", bus_if.bus_req, 1);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 16'h0042;
    tick();
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;
    check("race_writable", bus_if.writable, 1);
    check("race_err", bus_if.bus_err, 0);
    check("race_req_drop", bus_if.bus_req, 0);

    tick(); tick();
    check("wb_queue_empty", wb_q.size(), 0);
    check("err_pulse_count", n_err_pulses, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage of the 16-bit pipeline. It sits between the execute stage and the register file write port.
- Takes one instruction per handshake from execute and performs at most one data-memory transaction over a req/ack bus.
- Stalls upstream while that transaction is in flight.
- Drives the register file's writable/write_addr/write_value for exactly one cycle per retiring instruction.

Parameters:
- DATA_W, 16, register/memory data width
- REG_AW, 4, register address width
- MEM_AW, 16, data-memory address width
- TIMEOUT, 255, cycles in BUS state without ack before abort (range 1..65535)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  execute stage presents an instruction
- in_mem_read  in  1  instruction is a load
- in_mem_write  in  1  instruction is a store
- in_addr  in  MEM_AW  memory address (ALU result)
- in_store_data  in  DATA_W  store data
- in_reg_write  in  1  instruction writes a register
- in_reg_addr  in  REG_AW  destination register
- in_alu_value  in  DATA_W  writeback value for non-load instructions
- stall  out  1  upstream must hold its inputs stable
- bus_req  out  1  memory request
- bus_we  out  1  1 = write, 0 = read
- bus_addr  out  MEM_AW  request address
- bus_wdata  out  DATA_W  write data
- bus_ack  in  1  memory completed; bus_rdata valid in the same cycle
- bus_rdata  in  DATA_W  read data
- writable  out  1  register write enable (1 = write)
- write_addr  out  REG_AW  register write address
- write_value  out  DATA_W  register write data
- bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; the timeout counter clears.
  - All outputs go to 0.
  - Any in-flight transaction is dropped with no writeback and no bus_err.
  - First acceptance is possible on the first posedge after rst rises.
- States are IDLE and BUS. stall = (state == BUS); it is a registered-state decode, so no combinational path from inputs.
- Acceptance happens on a posedge with state == IDLE and in_valid == 1.
- Non-memory instruction (in_mem_read == 0 and in_mem_write == 0):
  - Next cycle: writable = in_reg_write, write_addr = in_reg_addr, write_value = in_alu_value.
  - Latency 1; state stays IDLE, so back-to-back acceptance happens every cycle.
- Memory instruction:
  - State goes to BUS; bus_req goes to 1 on the next cycle.
  - bus_we = in_mem_write; bus_addr and bus_wdata are latched.
  - The destination fields (in_reg_write, in_reg_addr) are latched.
  - If in_mem_write and in_mem_read are both 1, the instruction is treated as a store.
- BUS state:
  - bus_req, bus_we, bus_addr and bus_wdata are held constant; writable = 0.
  - The counter increments each cycle in BUS.
  - On a posedge with bus_ack == 1:
    - bus_req drops to 0 and state returns to IDLE.
    - Load: next cycle writable = latched reg_write, write_addr = latched addr, write_value = bus_rdata sampled at that edge.
    - Store: writable = 0 regardless of in_reg_write.
    - Minimum memory-op latency is 2 cycles (ack in the first BUS cycle).
  - Timeout: the counter reaches TIMEOUT with no ack.
    - bus_req drops and state returns to IDLE.
    - bus_err = 1 for one cycle; writable = 0, so no writeback.
    - A bus_ack arriving on the same edge as the timeout wins: normal completion, no bus_err.
- No new acceptance happens on the edge that leaves BUS. Upstream sees stall = 0 the following cycle and is accepted then.
- bus_ack seen in IDLE is ignored.
- Writeback outputs:
  - writable is high for exactly one cycle per retiring instruction and 0 otherwise.
  - write_addr/write_value hold their last values while writable = 0.
  - Register 0 is not filtered here; the register file discards writes to the zero register.
- Writeback outputs change only on posedge. The register file samples them on negedge, giving half-cycle setup.
- Arithmetic: the counter is 16 bits and saturates at TIMEOUT, never wrapping. No data arithmetic is performed.

Test Plan:
- Reset, then ALU op in_reg_write=1, in_reg_addr=3, in_alu_value=0x1234 → next cycle writable=1, write_addr=3, write_value=0x1234; the cycle after, writable=0.
- Load in_addr=0x8000, in_reg_addr=5; memory acks 3 cycles after bus_req rises with bus_rdata=0xBEEF → stall=1 for 3 cycles, bus_we=0, bus_addr=0x8000, then writable=1, write_addr=5, write_value=0xBEEF; back-to-back ALU op held until stall=0 and then retires 1 cycle later.
- Store in_addr=0x0010, in_store_data=0x00FF, in_reg_write=1, ack in the first BUS cycle → bus_we=1, bus_wdata=0x00FF, bus_req high exactly 1 cycle, writable never asserted.
- TIMEOUT=4, load with no ack → bus_req high 4 cycles then 0, bus_err pulses 1 cycle, writable stays 0; then bus_ack pulsed in IDLE → no effect.
- Assert rst low during BUS of a load → all outputs 0 immediately (asynchronous); after release, a later ack gives no writeback; a fresh ALU op retires normally.
- TIMEOUT=4, ack coincides with the 4th BUS cycle on a load with bus_rdata=0x0042 → writable=1, write_value=0x0042, bus_err stays 0.
